// File: rtl/scpad_dram_req_arbiter.sv
// rtl/scpad_dram_req_arbiter.sv - round-robin arbiter splitting scratchpad transfers into DRAM queue beats
module scpad_dram_req_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 32,
  parameter int ID_W       = 4,
  parameter int BYTES_W    = 7,
  parameter int BEAT_BYTES = 8
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*ID_W-1:0]    req_id,
  input  logic [NUM_REQ*BYTES_W-1:0] req_num_bytes,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic                       q_push,
  output logic                       q_write,
  output logic [ADDR_W-1:0]          q_addr,
  output logic [ID_W-1:0]            q_id,
  output logic [2:0]                 q_sub_id,
  output logic [2:0]                 q_num_request,
  output logic [BYTES_W-1:0]         q_num_bytes,
  input  logic                       dram_queue_full,
  input  logic                       be_stall,
  input  logic                       burst_complete,
  output logic                       busy
);

  localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BEAT_SH   = $clog2(BEAT_BYTES);
  localparam int MAX_BEATS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // arbitration
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic [PTR_W:0]   scan_idx;

  // fields of the requester currently winning arbitration
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [ID_W-1:0]    sel_id;
  logic [BYTES_W-1:0] sel_nb;

  // beat sizing of the winning transfer
  logic [BYTES_W-1:0] nb_eff;
  logic [BYTES_W:0]   beats_raw;
  logic               clamp;
  logic [2:0]         nreq_m1;
  logic [BYTES_W-1:0] last_bytes;

  // latched transfer
  logic               lat_write;
  logic [ADDR_W-1:0]  lat_addr;
  logic [ID_W-1:0]    lat_id;
  logic [2:0]         lat_nreq_m1;
  logic [BYTES_W-1:0] lat_last_bytes;
  logic [2:0]         sub_cnt;

  logic accept;
  logic push_ok;
  logic last_push;
  logic finish;

  // Scan requesters from rr_ptr upward (wrapping) and pick the first valid one
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan_idx[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Select the winner's transfer fields out of the flattened request buses
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_id    = '0;
    sel_nb    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_id    = req_id[i*ID_W +: ID_W];
        sel_nb    = req_num_bytes[i*BYTES_W +: BYTES_W];
      end
    end
  end

  // Beat count and last-beat size; zero-byte transfers move one byte, long ones clamp to 8 full beats
  always_comb begin
    nb_eff     = (sel_nb == '0) ? BYTES_W'(1) : sel_nb;
    beats_raw  = ({1'b0, nb_eff} + (BYTES_W+1)'(BEAT_BYTES - 1)) >> BEAT_SH;
    clamp      = (beats_raw > (BYTES_W+1)'(MAX_BEATS));
    nreq_m1    = clamp ? 3'd7 : 3'(beats_raw - 1'b1);
    last_bytes = clamp ? BYTES_W'(BEAT_BYTES)
                       : nb_eff - (BYTES_W'(nreq_m1) << BEAT_SH);
  end

  assign accept    = (state == IDLE) && grant_found;
  assign push_ok   = (state == ISSUE) && !dram_queue_full && !be_stall;
  assign last_push = push_ok && (sub_cnt == lat_nreq_m1);
  assign finish    = (state == WAIT_DONE) && burst_complete;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept -> issue beats -> wait for the queue to drain the burst
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (accept)    state_nxt = ISSUE;
      ISSUE:     if (last_push) state_nxt = WAIT_DONE;
      WAIT_DONE: if (finish)    state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Latch the granted transfer, count pushed beats, rotate priority past the owner on completion
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rr_ptr         <= '0;
      owner          <= '0;
      lat_write      <= 1'b0;
      lat_addr       <= '0;
      lat_id         <= '0;
      lat_nreq_m1    <= '0;
      lat_last_bytes <= '0;
      sub_cnt        <= '0;
    end else begin
      if (accept) begin
        owner          <= grant_idx;
        lat_write      <= sel_write;
        lat_addr       <= sel_addr;
        lat_id         <= sel_id;
        lat_nreq_m1    <= nreq_m1;
        lat_last_bytes <= last_bytes;
        sub_cnt        <= '0;
      end else if (push_ok) begin
        sub_cnt <= sub_cnt + 3'd1;
      end
      if (finish) begin
        rr_ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
      end
    end
  end

  // Outputs: handshakes and sub-request fields, fields held while a push is suppressed
  always_comb begin
    req_ready     = '0;
    req_done      = '0;
    q_push        = 1'b0;
    q_write       = 1'b0;
    q_addr        = '0;
    q_id          = '0;
    q_sub_id      = '0;
    q_num_request = '0;
    q_num_bytes   = '0;
    busy          = (state != IDLE);
    if (accept && nRST) begin
      req_ready[grant_idx] = 1'b1;
    end
    if (finish) begin
      req_done[owner] = 1'b1;
    end
    if (state == ISSUE) begin
      q_push        = push_ok;
      q_write       = lat_write;
      q_addr        = lat_addr + (ADDR_W'(sub_cnt) << BEAT_SH);
      q_id          = lat_id;
      q_sub_id      = sub_cnt;
      q_num_request = lat_nreq_m1;
      q_num_bytes   = (sub_cnt == lat_nreq_m1) ? lat_last_bytes : BYTES_W'(BEAT_BYTES);
    end
  end

endmodule

// File: tb/tb_scpad_dram_req_arbiter.sv
// tb/tb_scpad_dram_req_arbiter.sv - self-checking bench for scpad_dram_req_arbiter
module tb_scpad_dram_req_arbiter;

  localparam int NR = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr;
  logic [7:0]  req_id;
  logic [13:0] req_num_bytes;
  logic [1:0]  req_ready, req_done;
  logic        q_push, q_write;
  logic [31:0] q_addr;
  logic [3:0]  q_id;
  logic [2:0]  q_sub_id, q_num_request;
  logic [6:0]  q_num_bytes;
  logic        dram_queue_full, be_stall, burst_complete, busy;

  scpad_dram_req_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_id(req_id), .req_num_bytes(req_num_bytes),
    .req_ready(req_ready), .req_done(req_done),
    .q_push(q_push), .q_write(q_write), .q_addr(q_addr), .q_id(q_id),
    .q_sub_id(q_sub_id), .q_num_request(q_num_request), .q_num_bytes(q_num_bytes),
    .dram_queue_full(dram_queue_full), .be_stall(be_stall),
    .burst_complete(burst_complete), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        w;
    logic [31:0] addr;
    logic [3:0]  id;
    logic [2:0]  sub;
    logic [2:0]  nr;
    logic [6:0]  nb;
  } beat_t;

  typedef struct {
    int          r;
    int          mode;
    logic        w;
    logic [31:0] a;
    logic [6:0]  nb;
    logic [2:0]  e_nr;
    logic [6:0]  e_first;
    logic [6:0]  e_last;
    logic [31:0] e_last_a;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rr       = 0;

  beat_t pushes[$];
  int    push_cyc[$];
  int    ready_log[$];
  int    ready_cyc[$];
  int    done_log[$];

  logic        m_w[NR];
  logic [31:0] m_a[NR];
  logic [3:0]  m_id[NR];
  logic [6:0]  m_nb[NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // passive monitor: log pushes and handshakes, check one-hot / exclusivity
  always @(negedge CLK) begin
    if (q_push) begin
      pushes.push_back(beat_t'({q_write, q_addr, q_id, q_sub_id, q_num_request, q_num_bytes}));
      push_cyc.push_back(cyc);
    end
    if (req_ready != 2'b00) begin
      ready_log.push_back(req_ready[1] ? 1 : 0);
      ready_cyc.push_back(cyc);
    end
    if (req_done != 2'b00) done_log.push_back(req_done[1] ? 1 : 0);
    if ((req_ready | req_done) != 2'b00)
      chk("onehot_excl", {61'd0, $onehot0(req_ready), $onehot0(req_done),
                          (req_ready != 2'b00) && (req_done != 2'b00)}, 64'd6);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int r, input logic w, input logic [31:0] a,
                         input logic [3:0] id, input logic [6:0] nb);
    m_w[r] = w; m_a[r] = a; m_id[r] = id; m_nb[r] = nb;
    req_write[r]            = w;
    req_addr[r*32 +: 32]    = a;
    req_id[r*4 +: 4]        = id;
    req_num_bytes[r*7 +: 7] = nb;
  endtask

  // reference: number of beats for a transfer of requester r
  function automatic int exp_n(input int r);
    int nbe, n;
    nbe = (m_nb[r] == 0) ? 1 : int'(m_nb[r]);
    n = (nbe + 7) / 8;
    return (n > 8) ? 8 : n;
  endfunction

  // reference: beat k of requester r's transfer
  function automatic beat_t exp_beat(input int r, input int k);
    int nbe, n, left;
    beat_t b;
    nbe    = (m_nb[r] == 0) ? 1 : int'(m_nb[r]);
    n      = (nbe + 7) / 8;
    left   = nbe - k * 8;
    b.w    = m_w[r];
    b.addr = m_a[r] + 32'(k * 8);
    b.id   = m_id[r];
    b.sub  = 3'(k);
    b.nr   = 3'(((n > 8) ? 8 : n) - 1);
    b.nb   = (n > 8 || left > 8) ? 7'd8 : 7'(left);
    return b;
  endfunction

  // mode: 0 clean, 1 random backpressure + spurious completes, 2 full hold, 3 stall hold, 4 complete held in ISSUE
  task automatic serve(input int mode, input bit drop, output int g);
    int r0, p0, d0, exp_g, n, c;
    bit held;
    r0 = ready_log.size(); p0 = pushes.size(); d0 = done_log.size();
    exp_g = -1; held = 0;
    for (int i = 0; i < NR; i++) begin
      c = (rr + i) % NR;
      if (exp_g < 0 && req_valid[c]) exp_g = c;
    end
    for (int t = 0; t < 20 && ready_log.size() == r0; t++) tick();
    if (ready_log.size() == r0) begin
      chk("ready_timeout", 0, 1);
      g = 0;
      return;
    end
    g = ready_log[r0];
    chk("grant_idx", g, exp_g);
    if (drop) req_valid = 2'b00;
    n = exp_n(g);
    for (int t = 0; t < 400 && pushes.size() < p0 + n; t++) begin
      if (mode == 1) begin
        dram_queue_full = ($urandom_range(0, 3) == 0);
        be_stall        = ($urandom_range(0, 4) == 0);
        burst_complete  = 1'($urandom_range(0, 1));
      end
      if (mode == 4) burst_complete = 1'b1;
      if ((mode == 2 || mode == 3) && !held && pushes.size() == p0 + 1) begin
        held = 1;
        if (mode == 2) dram_queue_full = 1'b1; else be_stall = 1'b1;
        for (int h = 0; h < 5; h++) begin
          #1;
          chk("bp_nopush", q_push, 0);
          chk("bp_sub_id", q_sub_id, 1);
          chk("bp_addr", q_addr, m_a[g] + 32'd8);
          tick();
        end
        dram_queue_full = 1'b0;
        be_stall        = 1'b0;
      end
      tick();
    end
    dram_queue_full = 1'b0; be_stall = 1'b0; burst_complete = 1'b0;
    chk("push_count", pushes.size() - p0, n);
    for (int k = 0; k < n; k++)
      if (p0 + k < pushes.size()) chk("beat", pushes[p0+k], exp_beat(g, k));
    if (mode == 0 && pushes.size() >= p0 + n) begin
      chk("first_push_latency", push_cyc[p0] - ready_cyc[r0], 1);
      chk("beat_per_cycle", push_cyc[p0+n-1] - push_cyc[p0], n - 1);
    end
    #1;
    chk("wait_busy", busy, 1);
    chk("no_early_done", done_log.size() - d0, 0);
    tick();
    chk("still_waiting", busy, 1);
    burst_complete = 1'b1;
    tick();
    burst_complete = 1'b0;
    chk("done_count", done_log.size() - d0, 1);
    if (done_log.size() > d0) chk("done_idx", done_log[done_log.size()-1], g);
    chk("idle_after_done", busy, 0);
    rr = (g + 1) % NR;
  endtask

  vec_t tbl[10];
  int   g, gprev, p0, d0;

  initial begin
    tbl[0] = '{0, 0, 1'b1, 32'h0000_0100, 7'd20,  3'd2, 7'd8, 7'd4, 32'h0000_0110};
    tbl[1] = '{1, 0, 1'b0, 32'h0000_0200, 7'd0,   3'd0, 7'd1, 7'd1, 32'h0000_0200};
    tbl[2] = '{0, 0, 1'b1, 32'h0000_0300, 7'd64,  3'd7, 7'd8, 7'd8, 32'h0000_0338};
    tbl[3] = '{1, 0, 1'b0, 32'h0000_0400, 7'd100, 3'd7, 7'd8, 7'd8, 32'h0000_0438};
    tbl[4] = '{0, 0, 1'b1, 32'hFFFF_FFF8, 7'd16,  3'd1, 7'd8, 7'd8, 32'h0000_0000};
    tbl[5] = '{1, 2, 1'b0, 32'h0000_0500, 7'd32,  3'd3, 7'd8, 7'd8, 32'h0000_0518};
    tbl[6] = '{0, 3, 1'b1, 32'h0000_0600, 7'd32,  3'd3, 7'd8, 7'd8, 32'h0000_0618};
    tbl[7] = '{1, 4, 1'b0, 32'h0000_0700, 7'd9,   3'd1, 7'd8, 7'd1, 32'h0000_0708};
    tbl[8] = '{0, 0, 1'b0, 32'h0000_0800, 7'd127, 3'd7, 7'd8, 7'd8, 32'h0000_0838};
    tbl[9] = '{1, 0, 1'b1, 32'h0000_0010, 7'd1,   3'd0, 7'd1, 7'd1, 32'h0000_0010};

    nRST = 1'b0;
    req_valid = 2'b11; req_write = '0; req_addr = '0; req_id = '0; req_num_bytes = '0;
    dram_queue_full = 1'b0; be_stall = 1'b0; burst_complete = 1'b1;
    tick(); tick();
    chk("rst_ready", req_ready, 0);
    chk("rst_done", req_done, 0);
    chk("rst_push", q_push, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", q_addr, 0);
    req_valid = 2'b00; burst_complete = 1'b0;
    nRST = 1'b1;
    tick();

    // table-driven single transfers, boundaries and backpressure corners
    for (int v = 0; v < 10; v++) begin
      set_req(tbl[v].r, tbl[v].w, tbl[v].a, 4'(v), tbl[v].nb);
      req_valid = 2'(1 << tbl[v].r);
      p0 = pushes.size();
      serve(tbl[v].mode, 1'b1, g);
      if (pushes.size() > p0) begin
        chk("tbl_num_request", pushes[p0].nr, tbl[v].e_nr);
        chk("tbl_first_bytes", pushes[p0].nb, tbl[v].e_first);
        chk("tbl_last_bytes", pushes[pushes.size()-1].nb, tbl[v].e_last);
        chk("tbl_last_addr", pushes[pushes.size()-1].addr, tbl[v].e_last_a);
      end
      tick();
    end

    // fairness: both requesters held valid through several grants
    set_req(0, 1'b1, 32'h1000, 4'hA, 7'd8);
    set_req(1, 1'b0, 32'h2000, 4'hB, 7'd16);
    req_valid = 2'b11;
    gprev = -1;
    for (int i = 0; i < 4; i++) begin
      serve(0, 1'b0, g);
      if (i == 3) req_valid = 2'b00;
      if (gprev >= 0) chk("rr_alternate", g != gprev, 1);
      gprev = g;
    end
    tick();

    // randomized transfers with backpressure against the reference model
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < NR; r++)
        set_req(r, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                7'($urandom_range(0, 127)));
      req_valid = 2'($urandom_range(1, 3));
      serve(1, 1'b1, g);
      repeat ($urandom_range(0, 2)) tick();
    end

    // leave rr pointing at requester 1, then reset mid-ISSUE of a 4-beat transfer
    set_req(0, 1'b0, 32'h3000, 4'h1, 7'd8);
    req_valid = 2'b01;
    serve(0, 1'b1, g);
    set_req(1, 1'b1, 32'h4000, 4'h2, 7'd32);
    req_valid = 2'b10;
    p0 = pushes.size(); d0 = done_log.size();
    for (int t = 0; t < 30 && pushes.size() < p0 + 2; t++) tick();
    chk("pre_reset_pushes", pushes.size() - p0, 2);
    nRST = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("mid_rst_push", q_push, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_addr", q_addr, 0);
    burst_complete = 1'b1;
    tick(); tick();
    burst_complete = 1'b0;
    chk("rst_no_done", done_log.size() - d0, 0);
    chk("rst_no_extra_push", pushes.size() - p0, 2);
    set_req(0, 1'b1, 32'h5000, 4'h3, 7'd24);
    rr = 0;
    nRST = 1'b1;
    serve(0, 1'b1, g);
    chk("post_rst_grant0", g, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
